// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states,
// flag bit positions and the flag packing helper.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    MUL = 3'd4,
    DIV = 3'd5,
    NOT = 3'd6,
    XOR = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLG_N   = 3;
  localparam int FLG_Z   = 2;
  localparam int FLG_INV = 1;
  localparam int FLG_V   = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic inv, input logic v);
    logic [3:0] f;
    f          = 4'b0000;
    f[FLG_N]   = n;
    f[FLG_Z]   = z;
    f[FLG_INV] = inv;
    f[FLG_V]   = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply / divide engine: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, with a shared adder and sign fix-up.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // One extra magnitude bit so that |MIN| is representable.
  function automatic logic [WIDTH:0] mag_f(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] ext;
    ext = {x[WIDTH-1], x};
    if (x[WIDTH-1]) begin
      mag_f = ~ext + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      mag_f = ext;
    end
  endfunction

  logic [WIDTH:0]     hi_r, opnd_r;
  logic [WIDTH-1:0]   lo_r;
  logic               neg_r, mode_r, run_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     mag_a_s, mag_b_s, shifted_s, add_a_s, add_b_s, hi_nx_s;
  logic [WIDTH-1:0]   lo_nx_s;
  logic [WIDTH+1:0]   sum_s;
  logic               cin_s, done_s, ovf_s;
  logic [2*WIDTH-1:0] mag2_s, fix_s;

  assign mag_a_s = mag_f(a);
  assign mag_b_s = mag_f(b);
  assign done_s  = run_r && (cnt_r == LAST);

  // Shared adder: hi+multiplicand for MUL, shifted remainder minus divisor for DIV.
  always_comb begin
    shifted_s = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
    if (mode_r) begin
      add_a_s = shifted_s;
      add_b_s = ~opnd_r;
      cin_s   = 1'b1;
    end else begin
      add_a_s = hi_r;
      add_b_s = lo_r[0] ? opnd_r : {(WIDTH+1){1'b0}};
      cin_s   = 1'b0;
    end
    sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH+1){1'b0}}, cin_s};
    if (mode_r) begin
      hi_nx_s = sum_s[WIDTH+1] ? sum_s[WIDTH:0] : shifted_s;
      lo_nx_s = {lo_r[WIDTH-2:0], sum_s[WIDTH+1]};
    end else begin
      hi_nx_s = {1'b0, sum_s[WIDTH:1]};
      lo_nx_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up works on the post-step value so the final step's result is usable the same edge.
  always_comb begin
    if (mode_r) begin
      mag2_s = {{WIDTH{1'b0}}, lo_nx_s};
    end else begin
      mag2_s = {hi_nx_s[WIDTH-1:0], lo_nx_s};
    end
    if (neg_r) begin
      fix_s = ~mag2_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      fix_s = mag2_s;
    end
    if (mode_r) begin
      ovf_s = ~neg_r & lo_nx_s[WIDTH-1];
    end else begin
      ovf_s = (fix_s[2*WIDTH-1:WIDTH] != {WIDTH{fix_s[WIDTH-1]}});
    end
  end

  // Operand load on start, then WIDTH iteration steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r   <= {(WIDTH+1){1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {(WIDTH+1){1'b0}};
      neg_r  <= 1'b0;
      mode_r <= 1'b0;
      run_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (start) begin
      hi_r   <= {(WIDTH+1){1'b0}};
      lo_r   <= mode ? mag_a_s[WIDTH-1:0] : mag_b_s[WIDTH-1:0];
      opnd_r <= mode ? mag_b_s : mag_a_s;
      neg_r  <= a[WIDTH-1] ^ b[WIDTH-1];
      mode_r <= mode;
      run_r  <= 1'b1;
      cnt_r  <= {CW{1'b0}};
    end else if (run_r) begin
      hi_r <= hi_nx_s;
      lo_r <= lo_nx_s;
      if (done_s) begin
        run_r <= 1'b0;
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      run_r <= 1'b0;
    end
  end

  assign done   = done_s;
  assign result = fix_s[WIDTH-1:0];
  assign ovf    = ovf_s;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/add ops, iterative signed MUL/DIV,
// registered result and {N,Z,INV,V} flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] val_A,
  input  logic [WIDTH-1:0] val_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  alu_op_t            op_s;
  state_t             state_r;
  logic               out_valid_r, busy_r;
  logic [WIDTH-1:0]   alu_out_r;
  logic [3:0]         flags_r;
  logic [WIDTH-1:0]   res_s, add_s, sub_s, md_res_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               inv_s, v_s, iter_s, in_ready_s, accept_s;
  logic               md_start_s, md_mode_s, md_done_s, md_ovf_s;

  assign op_s       = alu_op_t'(op);
  assign add_s      = val_A + val_B;
  assign sub_s      = val_A - val_B;
  assign prod_s     = {{WIDTH{val_A[MSB]}}, val_A} * {{WIDTH{val_B[MSB]}}, val_B};
  assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign md_start_s = accept_s && iter_s;
  assign md_mode_s  = (op_s == DIV);

  // Single-cycle result and routing decision for the op being offered.
  always_comb begin
    res_s  = {WIDTH{1'b0}};
    inv_s  = 1'b0;
    v_s    = 1'b0;
    iter_s = 1'b0;
    case (op_s)
      ADD: begin
        res_s = add_s;
        v_s   = (val_A[MSB] == val_B[MSB]) && (add_s[MSB] != val_A[MSB]);
      end
      SUB: begin
        res_s = sub_s;
        v_s   = (val_A[MSB] != val_B[MSB]) && (sub_s[MSB] != val_A[MSB]);
      end
      AND: res_s = val_A & val_B;
      OR:  res_s = val_A | val_B;
      XOR: res_s = val_A ^ val_B;
      NOT: res_s = ~val_B;
      MUL: begin
        if (MUL_ITER != 0) begin
          iter_s = 1'b1;
        end else begin
          res_s = prod_s[WIDTH-1:0];
          v_s   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[MSB]}});
        end
      end
      DIV: begin
        if (val_B == {WIDTH{1'b0}}) begin
          inv_s = 1'b1;
        end else begin
          iter_s = 1'b1;
        end
      end
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_s),
    .mode   (md_mode_s),
    .a      (val_A),
    .b      (val_B),
    .done   (md_done_s),
    .result (md_res_s),
    .ovf    (md_ovf_s)
  );

  // Control FSM with registered result, flags and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      alu_out_r   <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            if (iter_s) begin
              state_r     <= BUSY;
              busy_r      <= 1'b1;
              out_valid_r <= 1'b0;
            end else begin
              state_r     <= DONE;
              busy_r      <= 1'b0;
              out_valid_r <= 1'b1;
              alu_out_r   <= res_s;
              flags_r     <= pack_flags(res_s[MSB], res_s == {WIDTH{1'b0}}, inv_s, v_s);
            end
          end else if ((state_r == DONE) && !out_ready) begin
            state_r <= DONE;
          end else begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        BUSY: begin
          if (md_done_s) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            alu_out_r   <= md_res_s;
            flags_r     <= pack_flags(md_res_s[MSB], md_res_s == {WIDTH{1'b0}}, 1'b0, md_ovf_s);
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign ALU_out   = alu_out_r;
  assign flags     = flags_r;
  assign busy      = busy_r;

endmodule
